// File: rtl/seq_mul8_if.sv
// Handshake and operand/result bundle for the iterative multiplier.
//   master : drives start, in1 (multiplicand), in2 (multiplier); observes busy, done, product
//   slave  : the multiplier side of the same signals
interface seq_mul8_if #(
   parameter int unsigned WIDTH = 8
);
   logic                 start;
   logic [WIDTH-1:0]     in1;
   logic [WIDTH-1:0]     in2;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   product;

   modport master (
      output start, in1, in2,
      input  busy, done, product
   );

   modport slave (
      input  start, in1, in2,
      output busy, done, product
   );
endinterface

// File: rtl/seq_mul8.sv
// Iterative shift-and-add unsigned multiplier for the execute stage.
// One multiply takes WIDTH RUN cycles; the product is held until the next completion.
//   clk     : rising-edge clock
//   rst_n   : asynchronous active-low reset
//   bus     : slave side of seq_mul8_if (start/in1/in2 in, busy/done/product out)
module seq_mul8 #(
   parameter int unsigned WIDTH = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   seq_mul8_if.slave   bus
);
   localparam int unsigned PW = 2 * WIDTH;
   localparam int unsigned CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          state;
   logic [PW-1:0]   mcand;
   logic [WIDTH-1:0] mplier;
   logic [PW-1:0]   acc;
   logic [CW-1:0]   cnt;
   logic            busy_q;
   logic            done_q;
   logic [PW-1:0]   product_q;
   logic [PW-1:0]   partial_c;
   logic [PW-1:0]   sum_c;

   // Partial product: multiplicand gated by the current multiplier LSB.
   always_comb begin
      partial_c = mcand & {PW{mplier[0]}};
      sum_c     = acc + partial_c;
   end

   // Control FSM and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         mcand     <= '0;
         mplier    <= '0;
         acc       <= '0;
         cnt       <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         product_q <= '0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  mcand  <= PW'(bus.in1);
                  mplier <= bus.in2;
                  acc    <= '0;
                  cnt    <= '0;
                  busy_q <= 1'b1;
                  state  <= S_RUN;
               end else begin
                  state  <= S_IDLE;
               end
            end
            S_RUN: begin
               acc    <= sum_c;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + CW'(1);
               // Last iteration: publish the final sum directly, not the stale acc.
               if (cnt == CW'(WIDTH - 1)) begin
                  product_q <= sum_c;
                  busy_q    <= 1'b0;
                  done_q    <= 1'b1;
                  state     <= S_DONE;
               end
            end
            default: begin
               busy_q <= 1'b0;
               done_q <= 1'b0;
               state  <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.product = product_q;
endmodule

// File: tb/tb_seq_mul8.sv
// Self-checking bench for seq_mul8: directed scenarios plus random operands,
// checked against plain arithmetic and a cycle-count model of the handshake.
module tb_seq_mul8;
   localparam int unsigned W = 8;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;
   logic [2*W-1:0] exp_prod;

   seq_mul8_if #(.WIDTH(W)) bus ();

   seq_mul8 #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One complete multiply. keep_start leaves start high after the accept edge;
   // inject>0 pulses start with other operands during that RUN iteration.
   task automatic mul(input logic [W-1:0] a, input logic [W-1:0] b,
                      input bit keep_start, input int inject);
      logic [2*W-1:0] prev;
      prev      = exp_prod;
      bus.in1   = a;
      bus.in2   = b;
      bus.start = 1'b1;
      tick();                                  // accept edge E0
      bus.start = keep_start;
      chk("accept_busy", 32'(bus.busy), 32'd1);
      chk("accept_done", 32'(bus.done), 32'd0);
      for (int i = 1; i < int'(W); i++) begin
         if (i == inject) begin
            bus.start = 1'b1;
            bus.in1   = 8'h02;
            bus.in2   = 8'h03;
         end
         tick();
         if (i == inject) bus.start = keep_start;
         if (!keep_start) begin
            bus.in1 = W'($urandom);
            bus.in2 = W'($urandom);
         end
         chk("run_busy", 32'(bus.busy), 32'd1);
         chk("run_done", 32'(bus.done), 32'd0);
         chk("run_hold", 32'(bus.product), 32'(prev));
      end
      tick();                                  // completion edge E_W
      exp_prod = (2*W)'(a) * (2*W)'(b);
      chk("cmpl_done", 32'(bus.done), 32'd1);
      chk("cmpl_busy", 32'(bus.busy), 32'd0);
      chk("cmpl_prod", 32'(bus.product), 32'(exp_prod));
      if (!keep_start) begin
         tick();                               // back to IDLE
         chk("idle_done", 32'(bus.done), 32'd0);
         chk("idle_busy", 32'(bus.busy), 32'd0);
         chk("idle_prod", 32'(bus.product), 32'(exp_prod));
      end
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      exp_prod  = '0;
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.in1   = '0;
      bus.in2   = '0;
      #1;
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_prod", 32'(bus.product), 32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // Basic multiply and corner operands.
      mul(8'h0D, 8'h0B, 1'b0, 0);
      chk("basic_val", 32'(exp_prod), 32'h008F);
      mul(8'hFF, 8'hFF, 1'b0, 0);
      chk("max_prod", 32'(bus.product), 32'hFE01);
      mul(8'h00, 8'hA5, 1'b0, 0);
      chk("zero_prod", 32'(bus.product), 32'h0000);

      // Start during RUN is ignored.
      mul(8'h0D, 8'h0B, 1'b0, 3);
      chk("ignore_prod", 32'(bus.product), 32'h008F);

      // Back-to-back with start held high; second accept lands in DONE.
      mul(8'h10, 8'h10, 1'b1, 0);
      chk("b2b_first", 32'(bus.product), 32'h0100);
      mul(8'h07, 8'h09, 1'b0, 0);
      chk("b2b_second", 32'(bus.product), 32'h003F);

      // Asynchronous reset mid-RUN.
      bus.in1   = 8'hFF;
      bus.in2   = 8'hFF;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      #2;
      rst_n = 1'b0;
      #1;
      exp_prod = '0;
      chk("arst_busy", 32'(bus.busy), 32'd0);
      chk("arst_done", 32'(bus.done), 32'd0);
      chk("arst_prod", 32'(bus.product), 32'd0);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("post_rst_done", 32'(bus.done), 32'd0);
         chk("post_rst_busy", 32'(bus.busy), 32'd0);
      end
      mul(8'h03, 8'h05, 1'b0, 0);
      chk("after_rst", 32'(bus.product), 32'h000F);

      // Random operands.
      for (int n = 0; n < 12; n++) begin
         logic [W-1:0] a;
         logic [W-1:0] b;
         a = W'($urandom);
         b = W'($urandom);
         mul(a, b, ($urandom_range(0, 1) == 1) && (n != 11), 0);
      end

      // Idle with toggling inputs: product must hold.
      for (int i = 0; i < 20; i++) begin
         bus.in1 = W'($urandom);
         bus.in2 = W'($urandom);
         tick();
         chk("idle_stable", 32'(bus.product), 32'(exp_prod));
         chk("idle_nobusy", 32'(bus.busy), 32'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
